// File: rtl/lcd_pixel_capture.sv
// Parallel RGB LCD receiver: recovers pixel coordinates from den/vsync strobes, checks
// frame geometry and queues tagged pixels in a small show-ahead FIFO with valid/ready output.
module lcd_pixel_capture #(
    parameter int HOR_PIX    = 480,
    parameter int VER_PIX    = 272,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk_12mhz,
    input  logic        rst,
    input  logic        pix_en,
    input  logic        hsync,
    input  logic        vsync,
    input  logic        den,
    input  logic [23:0] rgb,
    input  logic        err_clr,
    input  logic        out_ready,
    output logic        out_valid,
    output logic [23:0] out_rgb,
    output logic [10:0] out_x,
    output logic [10:0] out_y,
    output logic        out_sof,
    output logic        out_eol,
    output logic        frame_done,
    output logic        err_hcount,
    output logic        err_vcount,
    output logic        overflow,
    output logic        locked
);
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam logic [10:0]   HOR_L   = 11'(HOR_PIX);
    localparam logic [10:0]   VER_L   = 11'(VER_PIX);
    localparam logic [10:0]   LAST_X  = 11'(HOR_PIX - 1);
    localparam logic [CW-1:0] DEPTH_L = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, ACTIVE, DONE} state_t;

    typedef struct packed {
        logic        sof;
        logic        eol;
        logic [10:0] y;
        logic [10:0] x;
        logic [23:0] rgb;
    } entry_t;

    state_t      state_q, state_d, cur_state;
    logic [10:0] pix_cnt_q, pix_cnt_d, cur_pix;
    logic [10:0] line_cnt_q, line_cnt_d, cur_line;
    logic        prev_vsync_q, prev_vsync_d;
    logic        prev_hsync_q, prev_hsync_d;
    logic        prev_den_q, prev_den_d;
    logic        frame_done_q, frame_done_d;
    logic        frame_err_q, frame_err_d;
    logic        err_hcount_q, err_hcount_d;
    logic        err_vcount_q, err_vcount_d;
    logic        overflow_q, overflow_d;
    logic        locked_q, locked_d;

    entry_t      mem_q [FIFO_DEPTH];
    entry_t      mem_d [FIFO_DEPTH];
    entry_t      head_q, head_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;

    logic        vs_fall, de_fall;
    logic        push_req, push_ok, pop, full;
    logic        set_h, set_v, set_o, enter_done;
    entry_t      push_entry;

    // hsync is sampled for observability only; lines are delimited by den.
    logic        hsync_unused;
    assign hsync_unused = prev_hsync_q;

    always_comb begin
        state_d      = state_q;
        pix_cnt_d    = pix_cnt_q;
        line_cnt_d   = line_cnt_q;
        prev_vsync_d = prev_vsync_q;
        prev_hsync_d = prev_hsync_q;
        prev_den_d   = prev_den_q;
        frame_done_d = 1'b0;
        frame_err_d  = frame_err_q;
        vs_fall      = 1'b0;
        de_fall      = 1'b0;
        cur_state    = state_q;
        cur_pix      = pix_cnt_q;
        cur_line     = line_cnt_q;
        push_req     = 1'b0;
        push_entry   = '0;
        set_h        = 1'b0;
        set_v        = 1'b0;
        enter_done   = 1'b0;
        if (pix_en) begin
            prev_vsync_d = vsync;
            prev_hsync_d = hsync;
            prev_den_d   = den;
            vs_fall      = prev_vsync_q & ~vsync;
            de_fall      = prev_den_q & ~den;
            // Frame restart is resolved first so a coincident den strobe lands at (0,0).
            if (vs_fall) begin
                set_v       = (state_q == ACTIVE);
                cur_state   = ACTIVE;
                cur_pix     = '0;
                cur_line    = '0;
                frame_err_d = 1'b0;
            end
            state_d    = cur_state;
            pix_cnt_d  = cur_pix;
            line_cnt_d = cur_line;
            case (cur_state)
                ACTIVE: begin
                    if (den) begin
                        if (cur_pix < HOR_L) begin
                            push_req       = 1'b1;
                            push_entry.rgb = rgb;
                            push_entry.x   = cur_pix;
                            push_entry.y   = cur_line;
                            push_entry.sof = (cur_pix == '0) && (cur_line == '0);
                            push_entry.eol = (cur_pix == LAST_X);
                            pix_cnt_d      = cur_pix + 11'd1;
                        end else begin
                            set_h = 1'b1;
                        end
                    end else if (de_fall && !vs_fall) begin
                        set_h     = (cur_pix != HOR_L);
                        pix_cnt_d = '0;
                        if (cur_line < VER_L) begin
                            line_cnt_d = cur_line + 11'd1;
                        end
                        if (cur_line + 11'd1 == VER_L) begin
                            state_d      = DONE;
                            frame_done_d = 1'b1;
                            enter_done   = 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (den) begin
                        set_v = 1'b1;
                    end
                end
                default: ;
            endcase
            frame_err_d = frame_err_d | set_h;
        end
    end

    always_comb begin
        pop      = (count_q != '0) & out_ready;
        full     = (count_q == DEPTH_L);
        push_ok  = push_req & (~full | pop);
        set_o    = push_req & full & ~pop;
        mem_d    = mem_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = push_entry;
        end
        wr_ptr_d = wr_ptr_q + AW'(push_ok);
        rd_ptr_d = rd_ptr_q + AW'(pop);
        count_d  = count_q + CW'(push_ok) - CW'(pop);
        // Head register keeps the last entry visible once the FIFO runs empty.
        head_d   = (count_d != '0) ? mem_d[rd_ptr_d] : head_q;

        err_hcount_d = set_h | (err_hcount_q & ~err_clr);
        err_vcount_d = set_v | (err_vcount_q & ~err_clr);
        overflow_d   = set_o | (overflow_q & ~err_clr);
        if (set_h || set_v || set_o) begin
            locked_d = 1'b0;
        end else if (enter_done && !frame_err_d) begin
            locked_d = 1'b1;
        end else begin
            locked_d = locked_q;
        end
    end

    always_ff @(posedge clk_12mhz) begin
        mem_q <= mem_d;
        if (rst) begin
            state_q      <= IDLE;
            pix_cnt_q    <= '0;
            line_cnt_q   <= '0;
            prev_vsync_q <= 1'b1;
            prev_hsync_q <= 1'b1;
            prev_den_q   <= 1'b0;
            frame_done_q <= 1'b0;
            frame_err_q  <= 1'b0;
            err_hcount_q <= 1'b0;
            err_vcount_q <= 1'b0;
            overflow_q   <= 1'b0;
            locked_q     <= 1'b0;
            head_q       <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
        end else begin
            state_q      <= state_d;
            pix_cnt_q    <= pix_cnt_d;
            line_cnt_q   <= line_cnt_d;
            prev_vsync_q <= prev_vsync_d;
            prev_hsync_q <= prev_hsync_d;
            prev_den_q   <= prev_den_d;
            frame_done_q <= frame_done_d;
            frame_err_q  <= frame_err_d;
            err_hcount_q <= err_hcount_d;
            err_vcount_q <= err_vcount_d;
            overflow_q   <= overflow_d;
            locked_q     <= locked_d;
            head_q       <= head_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
        end
    end

    assign out_valid  = (count_q != '0);
    assign out_rgb    = head_q.rgb;
    assign out_x      = head_q.x;
    assign out_y      = head_q.y;
    assign out_sof    = head_q.sof;
    assign out_eol    = head_q.eol;
    assign frame_done = frame_done_q;
    assign err_hcount = err_hcount_q;
    assign err_vcount = err_vcount_q;
    assign overflow   = overflow_q;
    assign locked     = locked_q;

endmodule

// File: tb/tb_lcd_pixel_capture.sv
// Scoreboard bench for lcd_pixel_capture on a 4x3 frame with a 4-entry FIFO.
module tb_lcd_pixel_capture;
  localparam int HP    = 4;
  localparam int VP    = 3;
  localparam int DEPTH = 4;

  logic        clk_12mhz = 1'b0;
  logic        rst = 1'b1;
  logic        pix_en = 1'b0;
  logic        hsync = 1'b1;
  logic        vsync = 1'b1;
  logic        den = 1'b0;
  logic [23:0] rgb = '0;
  logic        err_clr = 1'b0;
  logic        out_ready = 1'b1;
  logic        out_valid;
  logic [23:0] out_rgb;
  logic [10:0] out_x;
  logic [10:0] out_y;
  logic        out_sof;
  logic        out_eol;
  logic        frame_done;
  logic        err_hcount;
  logic        err_vcount;
  logic        overflow;
  logic        locked;

  lcd_pixel_capture #(.HOR_PIX(HP), .VER_PIX(VP), .FIFO_DEPTH(DEPTH)) dut (
    .clk_12mhz (clk_12mhz),
    .rst       (rst),
    .pix_en    (pix_en),
    .hsync     (hsync),
    .vsync     (vsync),
    .den       (den),
    .rgb       (rgb),
    .err_clr   (err_clr),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_rgb   (out_rgb),
    .out_x     (out_x),
    .out_y     (out_y),
    .out_sof   (out_sof),
    .out_eol   (out_eol),
    .frame_done(frame_done),
    .err_hcount(err_hcount),
    .err_vcount(err_vcount),
    .overflow  (overflow),
    .locked    (locked)
  );

  // clock / reset
  always #5 clk_12mhz = ~clk_12mhz;

  logic [47:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  int fd_cnt = 0;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [47:0] make_exp(input logic [23:0] c, input int x, input int y);
    logic s, e;
    s = (x == 0) && (y == 0);
    e = (x == HP - 1);
    return {s, e, 11'(y), 11'(x), c};
  endfunction

  // scoreboard: compare every accepted head entry against the expected queue
  always @(negedge clk_12mhz) begin
    if (!rst) begin
      if (frame_done) fd_cnt++;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check_val("extra_pop", 64'(out_valid), 64'd0);
        end else begin
          check_val("pop", {16'd0, out_sof, out_eol, out_y, out_x, out_rgb}, {16'd0, exp_q.pop_front()});
        end
      end
    end
  end

  // driver tasks: one pix_en strobe followed by an ignored gap cycle carrying den noise
  task automatic strobe(input logic d, input logic v, input logic h, input logic [23:0] c);
    pix_en = 1'b1;
    den    = d;
    vsync  = v;
    hsync  = h;
    rgb    = c;
    @(posedge clk_12mhz); #1;
    pix_en = 1'b0;
    den    = ($urandom_range(0, 3) != 0);
    rgb    = 24'($urandom);
    @(posedge clk_12mhz); #1;
  endtask

  task automatic px(input int x, input int y, input bit exp_push);
    logic [23:0] c;
    c = 24'($urandom);
    if (exp_push) exp_q.push_back(make_exp(c, x, y));
    strobe(1'b1, 1'b1, 1'b1, c);
  endtask

  task automatic line_end();
    strobe(1'b0, 1'b1, 1'b0, 24'd0);
  endtask

  task automatic send_vsync();
    strobe(1'b0, 1'b0, 1'b1, 24'd0);
    strobe(1'b0, 1'b1, 1'b1, 24'd0);
  endtask

  task automatic send_line(input int y);
    for (int x = 0; x < HP; x++) px(x, y, 1'b1);
    line_end();
  endtask

  task automatic wait_drain(input string tag);
    for (int i = 0; i < 60 && exp_q.size() != 0; i++) begin
      @(posedge clk_12mhz); #1;
    end
    repeat (2) begin
      @(posedge clk_12mhz); #1;
    end
    check_val(tag, 64'(exp_q.size()), 64'd0);
  endtask

  task automatic pulse_clr();
    err_clr = 1'b1;
    @(posedge clk_12mhz); #1;
    err_clr = 1'b0;
  endtask

  initial begin
    repeat (3) @(posedge clk_12mhz);
    #1;
    rst = 1'b0;
    check_val("rst_valid", 64'(out_valid), 64'd0);
    check_val("rst_locked", 64'(locked), 64'd0);
    check_val("rst_flags", {61'd0, err_hcount, err_vcount, overflow}, 64'd0);
    check_val("rst_fdone", 64'(frame_done), 64'd0);
    check_val("rst_data", {29'd0, out_sof, out_eol, out_x, out_rgb[8:0]}, 64'd0);

    // clean frame
    send_vsync();
    for (int y = 0; y < VP; y++) send_line(y);
    wait_drain("clean_drain");
    check_val("clean_fdone", 64'(fd_cnt), 64'd1);
    check_val("clean_locked", 64'(locked), 64'd1);
    check_val("clean_flags", {61'd0, err_hcount, err_vcount, overflow}, 64'd0);

    // short line 1
    send_vsync();
    send_line(0);
    for (int x = 0; x < 3; x++) px(x, 1, 1'b1);
    line_end();
    send_line(2);
    wait_drain("short_drain");
    check_val("short_hcount", 64'(err_hcount), 64'd1);
    check_val("short_locked", 64'(locked), 64'd0);
    check_val("short_fdone", 64'(fd_cnt), 64'd2);
    pulse_clr();
    check_val("short_clr", 64'(err_hcount), 64'd0);

    // overflow: depth 4, fifth pixel dropped
    send_vsync();
    out_ready = 1'b0;
    send_line(0);
    px(0, 1, 1'b0);
    check_val("ovf_flag", 64'(overflow), 64'd1);
    check_val("ovf_valid", 64'(out_valid), 64'd1);
    pulse_clr();
    check_val("ovf_clr", 64'(overflow), 64'd0);
    out_ready = 1'b1;
    for (int x = 1; x < HP; x++) px(x, 1, 1'b1);
    line_end();
    send_line(2);
    wait_drain("ovf_drain");
    check_val("ovf_hcount", 64'(err_hcount), 64'd0);

    // early vsync after two lines
    send_vsync();
    send_line(0);
    send_line(1);
    send_vsync();
    check_val("vs_vcount", 64'(err_vcount), 64'd1);
    check_val("vs_locked", 64'(locked), 64'd0);
    send_line(0);
    pulse_clr();
    check_val("vs_clr", {62'd0, err_vcount, err_hcount}, 64'd0);
    send_line(1);
    send_line(2);
    wait_drain("vs_drain");
    check_val("vs_relock", 64'(locked), 64'd1);

    // reset mid-line with two entries held
    send_vsync();
    out_ready = 1'b0;
    px(0, 0, 1'b1);
    px(1, 0, 1'b1);
    check_val("mid_hold", 64'(out_valid), 64'd1);
    rst = 1'b1;
    exp_q.delete();
    @(posedge clk_12mhz); #1;
    rst = 1'b0;
    check_val("mid_valid", 64'(out_valid), 64'd0);
    check_val("mid_locked", 64'(locked), 64'd0);
    out_ready = 1'b1;
    for (int x = 0; x < 3; x++) px(x, 0, 1'b0);
    line_end();
    check_val("idle_nopush", 64'(out_valid), 64'd0);
    send_vsync();
    send_line(0);
    wait_drain("post_rst_drain");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
